// File: rtl/fpu.sv
// Two-stage single-precision FPU (add, sub, mul, div) with four IEEE rounding modes.
// Stage 1 registers the operands; stage 2 computes and registers the result and flags.
module fpu (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  rmode,
    input  logic [2:0]  fpu_op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] out,
    output logic        inf,
    output logic        snan,
    output logic        qnan,
    output logic        ine,
    output logic        overflow,
    output logic        underflow,
    output logic        zero,
    output logic        div_by_zero
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [31:0] r_opa, r_opb, r_out;
    logic [2:0]  r_op;
    logic [1:0]  r_rmode;
    logic        r_valid, r_inf, r_snan, r_qnan, r_ine, r_ovf, r_unf, r_zero, r_dbz;

    logic [7:0]  w_ea, w_eb, w_eL, w_eS, w_shift;
    logic [22:0] w_fa, w_fb;
    logic [23:0] w_ma, w_mb, w_mL, w_mS;
    logic        w_sa, w_sb, w_sx, w_sbEff, w_effSub, w_aBig, w_sticky;
    logic        w_aZero, w_bZero, w_aInf, w_bInf, w_aNan, w_bNan, w_snanIn;
    logic        w_isAdd, w_isMul, w_isDiv;
    logic [26:0] w_ext, w_aligned, w_quo, w_man;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [47:0] w_prod;
    logic [24:0] w_rem, w_mant;
    logic        w_divSticky, w_sign, w_inexact, w_roundUp;
    logic signed [9:0] w_exp, w_expR, w_mulExp, w_divExp;
    logic [31:0] w_ovfVal, w_out;
    logic        w_snan, w_ine, w_ovf, w_unf, w_dbz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_op    <= '0;
            r_rmode <= '0;
            r_valid <= 1'b0;
        end else begin
            r_opa   <= opa;
            r_opb   <= opb;
            r_op    <= fpu_op;
            r_rmode <= rmode;
            r_valid <= 1'b1;
        end
    end

    assign w_sa     = r_opa[31];
    assign w_sb     = r_opb[31];
    assign w_sx     = w_sa ^ w_sb;
    assign w_ea     = r_opa[30:23];
    assign w_eb     = r_opb[30:23];
    assign w_fa     = r_opa[22:0];
    assign w_fb     = r_opb[22:0];
    assign w_aZero  = (w_ea == 8'h00);
    assign w_bZero  = (w_eb == 8'h00);
    assign w_aInf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_bInf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_aNan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_bNan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_snanIn = (w_aNan && !w_fa[22]) || (w_bNan && !w_fb[22]);
    // Denormals carry a zero significand so they behave as signed zeros throughout.
    assign w_ma     = w_aZero ? 24'd0 : {1'b1, w_fa};
    assign w_mb     = w_bZero ? 24'd0 : {1'b1, w_fb};
    assign w_isAdd  = (r_op[2:1] == 2'b00);
    assign w_isMul  = (r_op == 3'b010);
    assign w_isDiv  = (r_op == 3'b011);

    assign w_sbEff   = w_sb ^ r_op[0];
    assign w_effSub  = w_sa ^ w_sbEff;
    assign w_aBig    = (r_opa[30:0] >= r_opb[30:0]);
    assign w_eL      = w_aBig ? w_ea : w_eb;
    assign w_eS      = w_aBig ? w_eb : w_ea;
    assign w_mL      = w_aBig ? w_ma : w_mb;
    assign w_mS      = w_aBig ? w_mb : w_ma;
    assign w_shift   = w_eL - w_eS;
    assign w_ext     = {w_mS, 3'b000};
    assign w_sticky  = |(w_ext & ((27'd1 << w_shift) - 27'd1));
    assign w_aligned = (w_ext >> w_shift) | {26'd0, w_sticky};
    assign w_sum     = w_effSub ? ({1'b0, w_mL, 3'b000} - {1'b0, w_aligned})
                                : ({1'b0, w_mL, 3'b000} + {1'b0, w_aligned});

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 27; i++)
            if (w_sum[i]) w_lz = 5'(26 - i);
    end

    assign w_prod   = {24'd0, w_ma} * {24'd0, w_mb};
    assign w_mulExp = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127
                      + (w_prod[47] ? 10'sd1 : 10'sd0);

    // Restoring division: one quotient bit per step, remainder kept below 2*divisor.
    always_comb begin
        w_rem = {1'b0, w_ma};
        w_quo = '0;
        for (int i = 26; i >= 0; i--) begin
            if (w_rem >= {1'b0, w_mb}) begin
                w_quo[i] = 1'b1;
                w_rem    = w_rem - {1'b0, w_mb};
            end
            w_rem = w_rem << 1;
        end
    end

    assign w_divSticky = |w_rem;
    assign w_divExp    = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127
                         - (w_quo[26] ? 10'sd0 : 10'sd1);

    always_comb begin
        w_sign = w_sx;
        w_exp  = w_divExp;
        w_man  = w_quo[26] ? {w_quo[26:1], w_quo[0] | w_divSticky} : {w_quo[25:0], w_divSticky};
        if (w_isAdd) begin
            w_sign = w_aBig ? w_sa : w_sbEff;
            if (w_sum[27]) begin
                w_man = {w_sum[27:2], w_sum[1] | w_sum[0]};
                w_exp = $signed({2'b00, w_eL}) + 10'sd1;
            end else begin
                w_man = w_sum[26:0] << w_lz;
                w_exp = $signed({2'b00, w_eL}) - $signed({5'd0, w_lz});
            end
        end else if (w_isMul) begin
            w_exp = w_mulExp;
            w_man = w_prod[47] ? {w_prod[47:22], |w_prod[21:0]} : {w_prod[46:21], |w_prod[20:0]};
        end
    end

    assign w_inexact = w_man[2] | w_man[1] | w_man[0];
    always_comb begin
        case (r_rmode)
            2'b00:   w_roundUp = w_man[2] & (w_man[1] | w_man[0] | w_man[3]);
            2'b01:   w_roundUp = 1'b0;
            2'b10:   w_roundUp = !w_sign & w_inexact;
            default: w_roundUp = w_sign & w_inexact;
        endcase
    end
    assign w_mant = {1'b0, w_man[26:3]} + {24'd0, w_roundUp};
    assign w_expR = w_exp + (w_mant[24] ? 10'sd1 : 10'sd0);

    always_comb begin
        case (r_rmode)
            2'b00:   w_ovfVal = {w_sign, 8'hFF, 23'd0};
            2'b01:   w_ovfVal = {w_sign, 31'h7F7FFFFF};
            2'b10:   w_ovfVal = w_sign ? 32'hFF7FFFFF : 32'h7F800000;
            default: w_ovfVal = w_sign ? 32'hFF800000 : 32'h7F7FFFFF;
        endcase
    end

    // Special operands take priority over the rounded datapath result.
    always_comb begin
        w_out  = {w_sign, w_expR[7:0], w_mant[24] ? w_mant[23:1] : w_mant[22:0]};
        w_snan = w_snanIn;
        w_ine  = 1'b0;
        w_ovf  = 1'b0;
        w_unf  = 1'b0;
        w_dbz  = 1'b0;
        if (r_op[2]) begin
            w_out  = QNAN;
            w_snan = 1'b0;
        end else if (w_aNan || w_bNan) begin
            w_out = QNAN;
        end else if (w_isAdd && (w_aInf || w_bInf)) begin
            w_out = (w_aInf && w_bInf && w_effSub) ? QNAN : {w_aInf ? w_sa : w_sbEff, 8'hFF, 23'd0};
        end else if (w_isAdd && (w_sum == 28'd0)) begin
            w_out = {w_effSub ? (r_rmode == 2'b11) : w_sa, 31'd0};
        end else if (w_isMul && (w_aInf || w_bInf)) begin
            w_out = (w_aZero || w_bZero) ? QNAN : {w_sx, 8'hFF, 23'd0};
        end else if (w_isMul && (w_aZero || w_bZero)) begin
            w_out = {w_sx, 31'd0};
        end else if (w_isDiv && ((w_aZero && w_bZero) || (w_aInf && w_bInf))) begin
            w_out = QNAN;
        end else if (w_isDiv && (w_aInf || w_bZero)) begin
            w_out = {w_sx, 8'hFF, 23'd0};
            w_dbz = w_bZero;
        end else if (w_isDiv && (w_bInf || w_aZero)) begin
            w_out = {w_sx, 31'd0};
        end else begin
            w_ine = w_inexact;
            if (w_expR >= 10'sd255) begin
                w_out = w_ovfVal;
                w_ovf = 1'b1;
                w_ine = 1'b1;
            end else if (w_expR <= 10'sd0) begin
                w_out = {w_sign, 31'd0};
                w_unf = 1'b1;
                w_ine = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= '0;
            r_inf  <= 1'b0;
            r_snan <= 1'b0;
            r_qnan <= 1'b0;
            r_ine  <= 1'b0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_zero <= 1'b0;
            r_dbz  <= 1'b0;
        end else if (r_valid) begin
            r_out  <= w_out;
            r_inf  <= (w_out[30:0] == 31'h7F800000);
            r_snan <= w_snan;
            r_qnan <= (w_out[30:23] == 8'hFF) && (w_out[22:0] != 23'd0);
            r_ine  <= w_ine;
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
            r_zero <= (w_out[30:0] == 31'd0);
            r_dbz  <= w_dbz;
        end
    end

    assign out         = r_out;
    assign inf         = r_inf;
    assign snan        = r_snan;
    assign qnan        = r_qnan;
    assign ine         = r_ine;
    assign overflow    = r_ovf;
    assign underflow   = r_unf;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_fpu.sv
// Directed self-checking bench for the fpu: reset behaviour, latency, rounding and special cases.
module tb_fpu;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_RES = 3'b100;
    // Flag vector order: {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}
    localparam logic [7:0] F_NONE = 8'h00;
    localparam logic [7:0] F_INF  = 8'h80;
    localparam logic [7:0] F_SNAN = 8'h40;
    localparam logic [7:0] F_QNAN = 8'h20;
    localparam logic [7:0] F_INE  = 8'h10;
    localparam logic [7:0] F_OVF  = 8'h08;
    localparam logic [7:0] F_UNF  = 8'h04;
    localparam logic [7:0] F_ZERO = 8'h02;
    localparam logic [7:0] F_DBZ  = 8'h01;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rmode;
    logic [2:0]  fpu_op;
    logic [31:0] opa, opb, out;
    logic        inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;
    int          assertCount = 0;
    int          failCount = 0;

    fpu dut (
        .clk(clk), .reset_n(reset_n), .rmode(rmode), .fpu_op(fpu_op),
        .opa(opa), .opb(opb), .out(out), .inf(inf), .snan(snan), .qnan(qnan),
        .ine(ine), .overflow(overflow), .underflow(underflow), .zero(zero),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Compares the registered result and the full flag vector against hand-computed values.
    task automatic checkOutput(input string tag, input logic [31:0] expOut, input logic [7:0] expFlags);
        logic [7:0] flags;
        flags = {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero};
        assertCount++;
        assert (out === expOut) else begin
            failCount++;
            $error("[TB] FAIL %s out: observed %h expected %h", tag, out, expOut);
        end
        assertCount++;
        assert (flags === expFlags) else begin
            failCount++;
            $error("[TB] FAIL %s flags{inf,snan,qnan,ine,ovf,unf,zero,dbz}: observed %b expected %b",
                   tag, flags, expFlags);
        end
    endtask

    // Drives one operation and waits out the two-cycle latency, ending just after the edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rm,
                                 input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        fpu_op = op;
        rmode  = rm;
        opa    = a;
        opb    = b;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        rmode   = 2'b00;
        fpu_op  = OP_ADD;
        opa     = 32'h0;
        opb     = 32'h0;
        #12;
        checkOutput("reset_hold", 32'h0, F_NONE);

        // Release reset with an add, then follow with a mul on the very next cycle.
        @(negedge clk);
        reset_n = 1'b1;
        fpu_op  = OP_ADD;
        opa     = 32'h3F800000;
        opb     = 32'h40000000;
        @(posedge clk);
        #1;
        fpu_op = OP_MUL;
        opa    = 32'h3F800000;
        opb    = 32'hC0000000;
        checkOutput("post_reset_gap", 32'h0, F_NONE);
        @(posedge clk);
        #1;
        checkOutput("add_1_plus_2", 32'h40400000, F_NONE);
        @(posedge clk);
        #1;
        checkOutput("mul_1_by_m2_b2b", 32'hC0000000, F_NONE);

        applyStimulus(OP_SUB, 2'b00, 32'h3F800000, 32'h3F800000);
        checkOutput("sub_zero_rne", 32'h00000000, F_ZERO);
        applyStimulus(OP_SUB, 2'b11, 32'h3F800000, 32'h3F800000);
        checkOutput("sub_zero_rmi", 32'h80000000, F_ZERO);
        applyStimulus(OP_DIV, 2'b00, 32'h3F800000, 32'h00000000);
        checkOutput("div_by_zero", 32'h7F800000, F_INF | F_DBZ);
        applyStimulus(OP_DIV, 2'b00, 32'h00000000, 32'h00000000);
        checkOutput("div_0_by_0", 32'h7FC00000, F_QNAN);
        applyStimulus(OP_ADD, 2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF);
        checkOutput("ovf_rne", 32'h7F800000, F_INF | F_OVF | F_INE);
        applyStimulus(OP_ADD, 2'b01, 32'h7F7FFFFF, 32'h7F7FFFFF);
        checkOutput("ovf_rtz", 32'h7F7FFFFF, F_OVF | F_INE);
        applyStimulus(OP_ADD, 2'b10, 32'hFF7FFFFF, 32'hFF7FFFFF);
        checkOutput("ovf_neg_rpi", 32'hFF7FFFFF, F_OVF | F_INE);
        applyStimulus(OP_ADD, 2'b11, 32'hFF7FFFFF, 32'hFF7FFFFF);
        checkOutput("ovf_neg_rmi", 32'hFF800000, F_INF | F_OVF | F_INE);
        applyStimulus(OP_ADD, 2'b00, 32'h7F800001, 32'h3F800000);
        checkOutput("snan_add", 32'h7FC00000, F_SNAN | F_QNAN);
        applyStimulus(OP_MUL, 2'b00, 32'h00800000, 32'h00800000);
        checkOutput("mul_underflow", 32'h00000000, F_UNF | F_INE | F_ZERO);
        applyStimulus(OP_RES, 2'b00, 32'h7F800001, 32'h3F800000);
        checkOutput("reserved_op", 32'h7FC00000, F_QNAN);

        applyStimulus(OP_DIV, 2'b00, 32'h40400000, 32'h40000000);
        checkOutput("div_3_by_2", 32'h3FC00000, F_NONE);
        applyStimulus(OP_DIV, 2'b00, 32'h3F800000, 32'h40400000);
        checkOutput("div_third_rne", 32'h3EAAAAAB, F_INE);
        applyStimulus(OP_DIV, 2'b01, 32'h3F800000, 32'h40400000);
        checkOutput("div_third_rtz", 32'h3EAAAAAA, F_INE);
        applyStimulus(OP_DIV, 2'b11, 32'hBF800000, 32'h40400000);
        checkOutput("div_mthird_rmi", 32'hBEAAAAAB, F_INE);
        applyStimulus(OP_MUL, 2'b00, 32'h40400000, 32'h40400000);
        checkOutput("mul_3_by_3", 32'h41100000, F_NONE);
        applyStimulus(OP_ADD, 2'b00, 32'h3F800000, 32'h33800000);
        checkOutput("tie_to_even", 32'h3F800000, F_INE);
        applyStimulus(OP_ADD, 2'b10, 32'h3F800000, 32'h33800000);
        checkOutput("round_up_rpi", 32'h3F800001, F_INE);
        applyStimulus(OP_ADD, 2'b00, 32'h3F7FFFFF, 32'h33000000);
        checkOutput("round_carry_out", 32'h3F800000, F_INE);
        applyStimulus(OP_ADD, 2'b01, 32'h3F7FFFFF, 32'h33000000);
        checkOutput("round_trunc", 32'h3F7FFFFF, F_INE);
        applyStimulus(OP_SUB, 2'b00, 32'h3F800001, 32'h3F800000);
        checkOutput("sub_cancel", 32'h34000000, F_NONE);
        applyStimulus(OP_SUB, 2'b00, 32'h40000000, 32'h3F800000);
        checkOutput("sub_2_minus_1", 32'h3F800000, F_NONE);
        applyStimulus(OP_ADD, 2'b00, 32'h00000001, 32'h3F800000);
        checkOutput("denormal_add", 32'h3F800000, F_NONE);
        applyStimulus(OP_MUL, 2'b00, 32'h3F800000, 32'h00400000);
        checkOutput("denormal_mul", 32'h00000000, F_ZERO);
        applyStimulus(OP_SUB, 2'b00, 32'h7F800000, 32'h7F800000);
        checkOutput("inf_minus_inf", 32'h7FC00000, F_QNAN);
        applyStimulus(OP_ADD, 2'b00, 32'h7F800000, 32'h3F800000);
        checkOutput("inf_plus_1", 32'h7F800000, F_INF);
        applyStimulus(OP_MUL, 2'b00, 32'h00000000, 32'h7F800000);
        checkOutput("zero_times_inf", 32'h7FC00000, F_QNAN);
        applyStimulus(OP_DIV, 2'b00, 32'h3F800000, 32'hFF800000);
        checkOutput("one_by_minf", 32'h80000000, F_ZERO);

        // Mid-stream reset clears everything at once; the next result still takes two cycles.
        applyStimulus(OP_ADD, 2'b00, 32'h3F800000, 32'h40000000);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_reset", 32'h0, F_NONE);
        @(negedge clk);
        reset_n = 1'b1;
        fpu_op  = OP_SUB;
        rmode   = 2'b00;
        opa     = 32'h3F800000;
        opb     = 32'h3F800000;
        @(posedge clk);
        #1;
        checkOutput("mid_reset_gap", 32'h0, F_NONE);
        @(posedge clk);
        #1;
        checkOutput("mid_reset_first", 32'h0, F_ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/fpu.md
FPU -- requirements
Module: fpu

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 rmode  input  2  rounding mode:
- 00 = nearest-even
- 01 = toward zero
- 10 = toward +inf
- 11 = toward -inf
REQ-004 fpu_op  input  3  operation:
- 000 = add
- 001 = sub
- 010 = mul
- 011 = div
- 100-111 = reserved
REQ-005 opa  input  32  IEEE-754 single-precision operand A.
REQ-006 opb  input  32  IEEE-754 single-precision operand B.
REQ-007 out  output  32  IEEE-754 single-precision result.
REQ-008 inf  output  1  out is +/-infinity.
REQ-009 snan  output  1  opa or opb is a signaling NaN (exp=FF, mantissa!=0, mantissa bit22=0).
REQ-010 qnan  output  1  out is a quiet NaN.
REQ-011 ine  output  1  result inexact (rounding discarded nonzero bits, or overflow/underflow occurred).
REQ-012 overflow  output  1  rounded exponent exceeded FE.
REQ-013 underflow  output  1  nonzero result too small for a normal number and flushed to zero.
REQ-014 zero  output  1  out is +/-0.
REQ-015 div_by_zero  output  1  fpu_op=div, opb is +/-0, and opa is finite and nonzero.

Function
REQ-016 Operands and op/rmode are registered on clk; out and all flags are registered; fixed latency 2 cycles from an input edge to the corresponding output.
REQ-017 Fully pipelined: a new operation may be applied every cycle; no handshake.
REQ-018 Inputs are sampled identically every cycle.
REQ-019 Denormal inputs are treated as signed zero (flush-to-zero).
REQ-020 Results below the minimum normal become signed zero, with underflow=1 and ine=1.
REQ-021 Add/sub: align by exponent difference with guard, round and sticky bits; normalize; round per rmode. sub = add with opb sign inverted.
REQ-022 Exact zero sum from opposite signs is +0, except in rmode 11, where it is -0.
REQ-023 Mul: 24x24 mantissa product; exponent = ea+eb-127; normalize, then round.
REQ-024 Div: 24-bit mantissa restoring quotient plus guard/round/sticky; exponent = ea-eb+127; normalize, then round.
REQ-025 Result sign: XOR of the operand signs for mul and div.
REQ-026 Rounding carry-out of the mantissa increments the exponent.
REQ-027 Overflow handling sets overflow=1 and ine=1; the result depends on rmode:
- nearest: signed inf
- toward zero: signed max finite 7F7FFFFF / FF7FFFFF
- +inf mode: +inf for positive, FF7FFFFF for negative
- -inf mode: -inf for negative, 7F7FFFFF for positive
REQ-028 Any NaN input produces out=7FC00000 and qnan=1; snan reflects the inputs.
REQ-029 Invalid operations produce 7FC00000 and qnan=1: inf-inf (effective subtraction), 0*inf, 0/0, inf/inf.
REQ-030 Infinity arithmetic:
- inf +/- finite = inf
- inf*nonzero = signed inf
- finite/inf = signed 0
- inf/finite = signed inf
REQ-031 Nonzero/0 = signed inf, with div_by_zero=1 and inf=1.
REQ-032 Reserved fpu_op produces out=7FC00000, qnan=1, other flags 0.
REQ-033 inf, qnan and zero are derived from the final registered out; they are mutually exclusive.

Reset
REQ-034 While reset_n=0: out=00000000 and all flags 0, asynchronously, including pipeline registers.
REQ-035 Pipeline contents in flight when reset asserts are discarded.
REQ-036 After reset_n rises, the first valid result appears 2 cycles after the first sampled input.
REQ-037 Between reset release and that first valid result, out=0 and all flags=0; zero stays 0 during reset.

Verification
REQ-038 reset_n=0 mid-stream -> out=00000000 and all flags 0 immediately; the first post-reset result appears at latency 2.
REQ-039 add 3F800000+40000000, rmode 00 -> 40400000, all flags 0, 2 cycles later; back-to-back with mul 3F800000*C0000000 -> C0000000 on the next cycle.
REQ-040 Signed-zero subtraction:
- sub 3F800000-3F800000, rmode 00 -> 00000000, zero=1
- same with rmode 11 -> 80000000
REQ-041 div 3F800000/00000000 -> 7F800000, div_by_zero=1, inf=1.
- div 00000000/00000000 -> 7FC00000, qnan=1, div_by_zero=0.
REQ-042 add 7F7FFFFF+7F7FFFFF:
- rmode 00 -> 7F800000, overflow=1, ine=1, inf=1
- rmode 01 -> 7F7FFFFF, overflow=1, ine=1, inf=0
REQ-043 NaN and underflow cases:
- add 7F800001+3F800000 -> 7FC00000, snan=1, qnan=1
- mul 00800000*00800000 -> 00000000, underflow=1, ine=1, zero=1
